// File: rtl/cic_ctrl_pkg.sv
// Shared types and helpers for the CIC decimator sequencing controller.
package cic_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    WARMUP = 2'd2,
    RUN    = 2'd3
  } ctrl_state_t;

  localparam int unsigned CNT_WIDTH_DEF  = 5;
  localparam int unsigned NUM_STAGES_DEF = 3;

  // A ratio of zero has no meaning for a decimator; treat it as pass-through.
  function automatic logic [31:0] sanitize_ratio(input logic [31:0] r);
    return (r == 32'd0) ? 32'd1 : r;
  endfunction

endpackage

// File: rtl/cic_dec_ctrl_phase.sv
// Modulo-R phase counter: advances on inc, wraps after ratio-1, clr has priority.
module cic_phase_cnt
  import cic_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CNT_WIDTH-1:0] ratio,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] phase,
  output logic                 wrap
);

  assign wrap = inc && (phase == (ratio - 1'b1));

  // Phase register: cleared, wrapped on the last slot, otherwise incremented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (inc) begin
      phase <= wrap ? '0 : phase + 1'b1;
    end
  end

endmodule

// File: rtl/cic_dec_ctrl.sv
// Sequencing controller for a CIC decimator: integrator/comb enables, warm-up
// suppression of outputs, ratio changes applied on a decimation boundary.
// Optional feature macro: CIC_DROP_CNT_EN adds the saturating drop_cnt port.
module cic_dec_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
  parameter int unsigned DROP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  valid_in,
  input  logic [CNT_WIDTH-1:0]  ratio_cfg,
  input  logic                  cfg_load,
  output logic                  integ_valid,
  output logic                  comb_valid,
  output logic                  out_valid,
  output logic                  stage_clr,
  output logic [CNT_WIDTH-1:0]  phase,
  output logic                  busy,
  output logic                  cfg_ack
`ifdef CIC_DROP_CNT_EN
  ,
  output logic [DROP_WIDTH-1:0] drop_cnt
`endif
);

  localparam int unsigned WC_W = $clog2(NUM_STAGES + 1);

  ctrl_state_t          state, state_nxt;
  logic [CNT_WIDTH-1:0] ratio_active, pending_ratio, ratio_cfg_s;
  logic                 pending, ack_q, vld_p1;
  logic [WC_W-1:0]      warm_cnt;
  logic                 active, cnt_inc, cnt_clr, wrap, apply, warm_last;

  assign ratio_cfg_s = CNT_WIDTH'(sanitize_ratio(32'(ratio_cfg)));
  assign active      = (state == WARMUP) || (state == RUN);
  assign cnt_inc     = active && valid_in;
  assign cnt_clr     = !enable || !active;
  assign apply       = (state == CLEAR) && pending && enable;
  assign warm_last   = (warm_cnt == WC_W'(NUM_STAGES - 1));

  cic_phase_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_phase (
    .clk   (clk),
    .rst_n (rst_n),
    .ratio (ratio_active),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .phase (phase),
    .wrap  (wrap)
  );

  assign integ_valid = cnt_inc;
  assign comb_valid  = wrap;
  assign stage_clr   = (state == CLEAR);
  assign busy        = (state != IDLE);
  assign cfg_ack     = ack_q | apply;
  assign out_valid   = vld_p1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: disable wins everywhere; a pending ratio restarts at a comb strobe.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = CLEAR;
      CLEAR:   state_nxt = enable ? WARMUP : IDLE;
      WARMUP: begin
        if (!enable)                state_nxt = IDLE;
        else if (wrap && pending)   state_nxt = CLEAR;
        else if (wrap && warm_last) state_nxt = RUN;
      end
      RUN: begin
        if (!enable)              state_nxt = IDLE;
        else if (wrap && pending) state_nxt = CLEAR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: active ratio, pending flag, ack, warm-up count, output strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ratio_active <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      pending      <= 1'b0;
      ack_q        <= 1'b0;
      warm_cnt     <= '0;
      vld_p1       <= 1'b0;
    end else begin
      ack_q  <= (state == IDLE) && cfg_load;
      // comb output register stage
      vld_p1 <= (state == RUN) && wrap;
      if (state == IDLE) begin
        pending <= 1'b0;
        if (cfg_load) ratio_active <= ratio_cfg_s;
      end else if (!enable) begin
        pending <= 1'b0;
      end else begin
        if (apply) begin
          ratio_active <= pending_ratio;
          pending      <= 1'b0;
        end
        if (cfg_load) pending <= 1'b1;
      end
      if ((state == WARMUP) && enable && wrap) begin
        warm_cnt <= warm_cnt + 1'b1;
      end else if (!active || !enable) begin
        warm_cnt <= '0;
      end
    end
  end

  // Requested ratio held until the next decimation boundary; only read while pending.
  always_ff @(posedge clk) begin
    if ((state != IDLE) && enable && cfg_load) begin
      pending_ratio <= ratio_cfg_s;
    end
  end

`ifdef CIC_DROP_CNT_EN
  // Samples arriving while idle or clearing are counted, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (valid_in && ((state == IDLE) || (state == CLEAR)) && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`else
  // Samples arriving while idle or clearing are silently ignored.
`endif

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Self-checking bench for cic_dec_ctrl: directed scenarios plus randomized
// traffic against a sample-counting reference model.
module tb_cic_dec_ctrl;

  localparam int NS = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, valid_in, cfg_load;
  logic [4:0]  ratio_cfg;
  logic        integ_valid, comb_valid, out_valid, stage_clr, busy, cfg_ack;
  logic [4:0]  phase;
`ifdef CIC_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: -1 idle, 0 clearing cycle, 1 streaming.
  int  m_mode;
  int  m_samples;
  int  m_ratio;
  int  m_pend_ratio;
  bit  m_pend, m_out_q, m_ack_q;
  int  m_drop;

  cic_dec_ctrl #(
    .CNT_WIDTH  (5),
    .NUM_STAGES (NS),
    .DROP_WIDTH (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .valid_in    (valid_in),
    .ratio_cfg   (ratio_cfg),
    .cfg_load    (cfg_load),
    .integ_valid (integ_valid),
    .comb_valid  (comb_valid),
    .out_valid   (out_valid),
    .stage_clr   (stage_clr),
    .phase       (phase),
    .busy        (busy),
    .cfg_ack     (cfg_ack)
`ifdef CIC_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = -1; m_samples = 0; m_ratio = 1; m_pend_ratio = 1;
    m_pend = 0; m_out_q = 0; m_ack_q = 0; m_drop = 0;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic cyc(input bit en, input bit v, input bit ld, input logic [4:0] cfg);
    bit idle, clr, act, in_run, e_integ, e_comb, go_clear;
    int e_phase, cfg_i;
    @(negedge clk);
    enable = en; valid_in = v; cfg_load = ld; ratio_cfg = cfg;
    #1;
    cfg_i   = int'(cfg);
    idle    = (m_mode < 0);
    clr     = (m_mode == 0);
    act     = !idle && !clr;
    e_phase = m_samples % m_ratio;
    e_integ = act && v;
    e_comb  = e_integ && (e_phase == m_ratio - 1);
    in_run  = act && ((m_samples / m_ratio) >= NS);
    chk("integ_valid", 32'(integ_valid), 32'(e_integ));
    chk("comb_valid",  32'(comb_valid),  32'(e_comb));
    chk("phase",       32'(phase),       32'(e_phase));
    chk("stage_clr",   32'(stage_clr),   32'(clr));
    chk("busy",        32'(busy),        32'(!idle));
    chk("out_valid",   32'(out_valid),   32'(m_out_q));
    chk("cfg_ack",     32'(cfg_ack),     32'(m_ack_q | (clr && m_pend && en)));
`ifdef CIC_DROP_CNT_EN
    chk("drop_cnt",    32'(drop_cnt),    32'(m_drop));
    if (v && (idle || clr) && m_drop != 65535) m_drop++;
`endif
    m_out_q = e_comb && in_run;
    m_ack_q = idle && ld;
    if (idle) begin
      m_pend = 0;
      if (ld) m_ratio = (cfg_i == 0) ? 1 : cfg_i;
      if (en) begin m_mode = 0; m_samples = 0; end
    end else if (!en) begin
      m_mode = -1; m_samples = 0; m_pend = 0;
    end else begin
      go_clear = e_comb && m_pend;
      if (clr && m_pend) begin m_ratio = m_pend_ratio; m_pend = 0; end
      if (ld) begin m_pend_ratio = (cfg_i == 0) ? 1 : cfg_i; m_pend = 1; end
      if (clr) m_mode = 1;
      else if (go_clear) begin m_mode = 0; m_samples = 0; end
      else if (e_integ) m_samples++;
    end
  endtask

  // Continuous samples until out_valid is seen; n = samples fed before that cycle.
  task automatic feed_until_out(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      cyc(1, 1, 0, 5'd0);
      if (out_valid === 1'b1) begin
        n = i - 1;
        break;
      end
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop immediately.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0; enable = 0; valid_in = 0; cfg_load = 0;
    #1;
    chk("rst_busy",      32'(busy),        32'd0);
    chk("rst_phase",     32'(phase),       32'd0);
    chk("rst_out_valid", 32'(out_valid),   32'd0);
    chk("rst_cfg_ack",   32'(cfg_ack),     32'd0);
    chk("rst_stage_clr", 32'(stage_clr),   32'd0);
    chk("rst_integ",     32'(integ_valid), 32'd0);
    chk("rst_comb",      32'(comb_valid),  32'd0);
`ifdef CIC_DROP_CNT_EN
    chk("rst_drop_cnt",  32'(drop_cnt),    32'd0);
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    bit found;
    rst_n = 1'b0; enable = 0; valid_in = 0; cfg_load = 0; ratio_cfg = '0;
    model_reset();
    do_reset();

    // Ratio load while idle: ack one cycle later, nothing else moves.
    cyc(0, 0, 1, 5'd4);
    cyc(0, 0, 0, 5'd0);
    chk("idle_cfg_ack", 32'(cfg_ack), 32'd1);
    chk("idle_busy",    32'(busy),    32'd0);

    // R=4: one clear cycle that swallows its sample, first output after sample 16.
    cyc(1, 0, 0, 5'd0);
    cyc(1, 1, 0, 5'd0);
    chk("clear_stage_clr", 32'(stage_clr),   32'd1);
    chk("clear_drops",     32'(integ_valid), 32'd0);
    feed_until_out(n);
    chk("first_out_r4", 32'(n), 32'd16);
    feed_until_out(n);
    chk("out_spacing_r4", 32'(n + 1), 32'd4);

    // Ratio change to 8 requested at phase 1 takes effect after phase 3 wraps.
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      cyc(1, 1, 0, 5'd0);
      found = (phase == 5'd0);
    end
    cyc(1, 1, 1, 5'd8);
    chk("load_phase", 32'(phase), 32'd1);
    cyc(1, 1, 0, 5'd0);
    chk("no_early_clr", 32'(stage_clr), 32'd0);
    cyc(1, 1, 0, 5'd0);
    chk("boundary_comb", 32'(comb_valid), 32'd1);
    cyc(1, 1, 0, 5'd0);
    chk("chg_stage_clr", 32'(stage_clr), 32'd1);
    chk("chg_cfg_ack",   32'(cfg_ack),   32'd1);
    chk("chg_last_out",  32'(out_valid), 32'd1);
    feed_until_out(n);
    chk("first_out_r8", 32'(n), 32'd32);

    // Ratio 0 behaves as 1: three strobes discarded, output from the fourth.
    cyc(0, 0, 0, 5'd0);
    cyc(0, 0, 1, 5'd0);
    cyc(1, 0, 0, 5'd0);
    cyc(1, 0, 0, 5'd0);
    feed_until_out(n);
    chk("first_out_r1", 32'(n), 32'd4);

    // Disable during warm-up with a pending ratio: it is discarded.
    cyc(0, 0, 0, 5'd0);
    cyc(0, 0, 1, 5'd4);
    cyc(1, 0, 0, 5'd0);
    cyc(1, 0, 0, 5'd0);
    repeat (5) cyc(1, 1, 0, 5'd0);
    cyc(1, 1, 1, 5'd8);
    cyc(0, 0, 0, 5'd0);
    cyc(0, 0, 0, 5'd0);
    chk("dis_cfg_ack", 32'(cfg_ack), 32'd0);
    chk("dis_phase",   32'(phase),   32'd0);
    chk("dis_busy",    32'(busy),    32'd0);
    cyc(1, 0, 0, 5'd0);
    cyc(1, 0, 0, 5'd0);
    chk("reen_no_ack", 32'(cfg_ack), 32'd0);
    feed_until_out(n);
    chk("reen_old_ratio", 32'(n), 32'd16);

    // Reset in the middle of streaming.
    repeat (3) cyc(1, 1, 0, 5'd0);
    do_reset();
    cyc(0, 0, 0, 5'd0);

    // Randomized traffic: loads, gaps and occasional disables.
    for (int s = 0; s < 8; s++) begin
      cyc(0, 0, 0, 5'd0);
      cyc(0, 0, 1, 5'($urandom_range(0, 12)));
      for (int i = 0; i < 150; i++) begin
        cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 39) == 0), 5'($urandom_range(0, 31)));
      end
    end

`ifdef CIC_DROP_CNT_EN
    // Drops: 5 idle samples plus 1 in the clear cycle, then saturation.
    do_reset();
    repeat (5) cyc(0, 1, 0, 5'd0);
    cyc(1, 0, 0, 5'd0);
    cyc(1, 1, 0, 5'd0);
    cyc(1, 0, 0, 5'd0);
    chk("drop_six", 32'(drop_cnt), 32'd6);
    cyc(0, 0, 0, 5'd0);
    repeat (65540) cyc(0, 1, 0, 5'd0);
    cyc(0, 0, 0, 5'd0);
    chk("drop_sat", 32'(drop_cnt), 32'h0000FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
